// File: rtl/l1_bank_giver_if.sv
// Host write port, commit/frame controls and L1 byte stream of l1_bank_giver.
interface l1_bank_giver_if #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 7
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              commit;
    logic [LEN_W-1:0]  commit_len;
    logic              frame_start;
    logic [7:0]        l1_data;
    logic              l1_load;
    logic              l1_busy;
    logic              commit_pending;
    logic              overrun;
    logic              wr_reject;

    modport master (
        output wr_en, wr_addr, wr_data, commit, commit_len, frame_start,
        input  l1_data, l1_load, l1_busy, commit_pending, overrun, wr_reject
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, commit_len, frame_start,
        output l1_data, l1_load, l1_busy, commit_pending, overrun, wr_reject
    );
endinterface

// File: rtl/l1_bank_giver.sv
// Double-banked L1 signalling source: host fills the shadow bank, COMMIT swaps
// banks between bursts, FRAME_START streams the active bank as a gapless burst.
module l1_bank_giver #(
    parameter int MAX_BYTES = 64,
    parameter int ADDR_W    = 6,
    parameter int LEN_W     = 7
) (
    input logic             CLK,
    input logic             RST,
    l1_bank_giver_if.slave  bus
);
    localparam logic [31:0]      MAX_U   = MAX_BYTES;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    typedef enum logic {IDLE, READ} state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem [2][MAX_BYTES];
    logic [LEN_W-1:0] len_q [2];
    logic             act_q;
    logic             pend_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cur_len_q;
    logic [7:0]       data_q;
    logic             load_q;
    logic             ovr_q;
    logic             rej_q;

    logic             sel;
    logic             start;
    logic             finish;
    logic             wr_ok;
    logic             swap;
    logic [LEN_W-1:0] clen;

    // Next state, burst start/finish, write acceptance and bank swap decision.
    // A commit that lands on the last byte cycle leaves the swap pending into
    // IDLE; while it is pending, sel points at the bank about to become active
    // so a FRAME_START on that swap cycle reads the new contents.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        sel     = act_q ^ ((state_q == IDLE) && pend_q);
        case (state_q)
            IDLE: begin
                if (bus.frame_start && (len_q[sel] != '0)) begin
                    start   = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                if (cnt_q == cur_len_q) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_ok = bus.wr_en && !pend_q && (32'(bus.wr_addr) < MAX_U);
        clen  = (32'(bus.commit_len) > MAX_U) ? MAX_LEN : bus.commit_len;
        swap  = ((state_q == IDLE) && pend_q)
              || (finish && pend_q)
              || ((state_q == IDLE) && bus.commit && !bus.frame_start);
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Shadow bank RAM write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_ok) mem[!act_q][bus.wr_addr] <= bus.wr_data;
    end

    // Bank bookkeeping, readout counter and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            act_q     <= 1'b0;
            pend_q    <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) len_q[i] <= '0;
            cnt_q     <= '0;
            cur_len_q <= '0;
            data_q    <= '0;
            load_q    <= 1'b0;
            ovr_q     <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            if (bus.commit) len_q[!act_q] <= clen;
            if (swap) act_q <= !act_q;
            pend_q <= swap ? 1'b0 : (pend_q || bus.commit);
            if (start) begin
                cur_len_q <= len_q[sel];
                cnt_q     <= LEN_W'(1);
                data_q    <= mem[sel][0];
                load_q    <= 1'b1;
            end else if (state_q == READ) begin
                if (finish) begin
                    load_q <= 1'b0;
                end else begin
                    data_q <= mem[act_q][cnt_q[ADDR_W-1:0]];
                    cnt_q  <= cnt_q + LEN_W'(1);
                end
            end
            ovr_q <= (state_q == READ) && bus.frame_start;
            rej_q <= bus.wr_en && !wr_ok;
        end
    end

    assign bus.l1_data        = data_q;
    assign bus.l1_load        = load_q;
    assign bus.l1_busy        = (state_q == READ);
    assign bus.commit_pending = pend_q;
    assign bus.overrun        = ovr_q;
    assign bus.wr_reject      = rej_q;
endmodule

// File: tb/tb_l1_bank_giver.sv
// Randomized and directed bench for l1_bank_giver against a queue-based model.
module tb_l1_bank_giver;
    localparam int MB     = 48;
    localparam int ADDR_W = 6;
    localparam int LEN_W  = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    l1_bank_giver_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    l1_bank_giver #(.MAX_BYTES(MB), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: byte banks, lengths, active index and queue of bytes
    // still to be shown in the current burst.
    logic [7:0] bank [2][MB];
    int         blen [2];
    int         act;
    bit         pend;
    logic [7:0] q [$];
    bit         exp_load, exp_busy, exp_pend, exp_ovr, exp_rej;
    logic [7:0] exp_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        act = 0; pend = 0; blen[0] = 0; blen[1] = 0;
        q.delete();
        exp_load = 0; exp_busy = 0; exp_pend = 0; exp_ovr = 0; exp_rej = 0;
        exp_data = '0;
    endtask

    task automatic model_step(input bit fs, input bit cm, input int clen,
                              input bit we, input int wa, input logic [7:0] wd);
        bit old_pend;
        bit acc;
        int c;
        int eb;
        int len;
        old_pend = pend;
        c   = (clen > MB) ? MB : clen;
        acc = we && !old_pend && (wa < MB);
        exp_rej = we && !acc;
        if (acc) bank[1-act][wa] = wd;
        exp_ovr = exp_load && fs;
        if (exp_load) begin
            if (cm) blen[1-act] = c;
            if (q.size() == 0) begin
                exp_load = 0;
                if (old_pend) begin act = 1 - act; pend = 0; end
                else if (cm) pend = 1;
            end else begin
                exp_data = q.pop_front();
                if (cm) pend = 1;
            end
        end else begin
            eb  = old_pend ? 1 - act : act;
            len = blen[eb];
            if (cm) blen[1-act] = c;
            if (old_pend) begin act = 1 - act; pend = 0; end
            else if (cm) begin
                if (fs) pend = 1;
                else act = 1 - act;
            end
            if (fs && len > 0) begin
                for (int i = 0; i < len; i++) q.push_back(bank[eb][i]);
                exp_data = q.pop_front();
                exp_load = 1;
            end
        end
        exp_busy = exp_load;
        exp_pend = pend;
    endtask

    task automatic check_outputs();
        check("l1_load", bus.l1_load, exp_load);
        check("l1_data", bus.l1_data, exp_data);
        check("l1_busy", bus.l1_busy, exp_busy);
        check("commit_pending", bus.commit_pending, exp_pend);
        check("overrun", bus.overrun, exp_ovr);
        check("wr_reject", bus.wr_reject, exp_rej);
    endtask

    // One clock cycle: drive inputs at the falling edge, step the model, and
    // compare outputs at the following falling edge.
    task automatic cyc(input bit fs, input bit cm, input int clen,
                       input bit we, input int wa, input int wd);
        bus.frame_start = fs;
        bus.commit      = cm;
        bus.commit_len  = LEN_W'(clen);
        bus.wr_en       = we;
        bus.wr_addr     = ADDR_W'(wa);
        bus.wr_data     = 8'(wd);
        model_step(fs, cm, clen, we, wa, 8'(wd));
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int wa, input int wd);
        cyc(0, 0, 0, 1, wa, wd);
    endtask

    initial begin
        bus.frame_start = 0; bus.commit = 0; bus.commit_len = '0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst = 1'b1;
        idle(2);

        // Basic load and burst.
        wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44);
        cyc(0, 1, 4, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(5);

        // Commit during a burst is deferred until the burst ends.
        wr(0, 8'hAA); wr(1, 8'hBB);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 2, 0, 0, 0);
        idle(5);
        cyc(1, 0, 0, 0, 0, 0);
        idle(4);

        // Writes while pending or out of range are rejected.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 8'hFF);
        idle(3);
        cyc(1, 0, 0, 0, 0, 0);
        idle(3);
        wr(MB, 8'h5A);
        wr(MB + 3, 8'h5B);
        idle(1);

        // Overrun on the first and last byte cycles of a 4-byte burst.
        for (int i = 0; i < 4; i++) wr(i, 8'h60 + i);
        cyc(0, 1, 4, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0);
        idle(4);

        // Commit together with frame start, and on the last byte cycle.
        cyc(1, 1, 3, 0, 0, 0);
        idle(2);
        cyc(0, 1, 2, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(4);

        // Length clamp and zero length.
        for (int i = 0; i < MB; i++) wr(i, $urandom_range(0, 255));
        cyc(0, 1, MB + 5, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(MB + 2);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(3);

        // Reset mid-burst drops the burst at once and clears the lengths.
        for (int i = 0; i < 4; i++) wr(i, 8'h70 + i);
        cyc(0, 1, 4, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 4; i++) wr(i, 8'h80 + i);
        cyc(0, 1, 4, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(5);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            cyc($urandom_range(0, 99) < 12,
                $urandom_range(0, 99) < 6,
                $urandom_range(0, MB + 8),
                $urandom_range(0, 99) < 40,
                $urandom_range(0, MB + 4),
                $urandom_range(0, 255));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/l1_bank_giver.md
Name: l1_bank_giver

Overview:
- Parametrised successor to the fixed-content L1 signalling source that feeds the T2-MI packer's L1_DATA/L1_LOAD inputs.
- Holds L1 signalling bytes in two banks: an active bank that is read out and a shadow bank that is written.
- A host-side write port fills the shadow bank; COMMIT swaps the banks atomically, never in the middle of a readout.
- Each FRAME_START request streams the active bank as a gapless byte burst with a load strobe.

Parameters:
- MAX_BYTES, 64: capacity of each bank in bytes (2..256).
- ADDR_W, 6: write address width; 2**ADDR_W >= MAX_BYTES.
- LEN_W, 7: length field width; 2**LEN_W > MAX_BYTES.

Ports:
- CLK  in  1  single system clock; all logic on its rising edge.
- RST  in  1  reset, asynchronous, active-low.
- WR_EN  in  1  write strobe to the shadow bank.
- WR_ADDR  in  ADDR_W  shadow byte address.
- WR_DATA  in  8  shadow byte data.
- COMMIT  in  1  one-cycle request to make the shadow bank active.
- COMMIT_LEN  in  LEN_W  byte count of the shadow contents; sampled with COMMIT.
- FRAME_START  in  1  one-cycle request to emit the active bank.
- L1_DATA  out  8  L1 byte.
- L1_LOAD  out  1  qualifies L1_DATA; one byte per cycle.
- L1_BUSY  out  1  readout in progress.
- COMMIT_PENDING  out  1  commit accepted, swap deferred.
- OVERRUN  out  1  one-cycle pulse: FRAME_START dropped.
- WR_REJECT  out  1  one-cycle pulse: write dropped.

Behaviour:
- Reset (RST low, async):
  - Outputs: L1_DATA=0, L1_LOAD=0, L1_BUSY=0, COMMIT_PENDING=0, OVERRUN=0, WR_REJECT=0.
  - Internal state: active=bank0, both lengths=0, state=IDLE.
  - Bank RAM contents are not reset.
- States:
  - IDLE: waiting for a request.
  - READ: emitting bytes; read counter runs 0..len-1.
- Readout:
  - FRAME_START sampled high in IDLE with active length L>0 causes:
    - L1_LOAD=1 and L1_BUSY=1 on cycles t+1..t+L;
    - L1_DATA = active[0..L-1] in order;
    - return to IDLE after cycle t+L.
  - L is latched at start.
  - L1_DATA is held at its last value when L1_LOAD=0.
- FRAME_START in IDLE with L=0: no burst, no OVERRUN.
- FRAME_START during READ (including the last byte cycle): ignored; OVERRUN=1 on the next cycle; the burst continues unchanged.
- Writes:
  - WR_EN always targets the shadow bank.
  - A write is accepted only when COMMIT_PENDING=0 and WR_ADDR<MAX_BYTES.
  - Otherwise the write is dropped and WR_REJECT=1 on the next cycle.
- Commit:
  - COMMIT_LEN is clamped to MAX_BYTES and stored as the shadow length.
  - COMMIT in IDLE without FRAME_START: the banks swap at that edge; the following FRAME_START reads the new bank.
  - COMMIT during READ, or together with FRAME_START in IDLE:
    - the burst uses the old bank;
    - COMMIT_PENDING=1 from the next cycle;
    - the swap happens on the cycle after the last byte, and COMMIT_PENDING clears then.
  - A FRAME_START arriving on the swap cycle is served from the new bank.
  - COMMIT while COMMIT_PENDING=1: the later COMMIT_LEN overwrites the pending length; one swap only.
  - WR_EN together with COMMIT (not pending): the write lands before the swap and is included in the new bank.
- Reset asserted mid-burst: L1_LOAD drops immediately; after release the block is in IDLE with length 0, so FRAME_START yields no burst until a COMMIT.
- Latency: exactly one cycle from FRAME_START to the first L1_LOAD.
- Throughput: minimum FRAME_START spacing is L+1 cycles.

Test Plan:
1. Reset, then write shadow[0..3]=0x11,0x22,0x33,0x44, COMMIT with COMMIT_LEN=4, then FRAME_START -> L1_LOAD high for 4 cycles beginning 1 cycle after FRAME_START; L1_DATA 11,22,33,44; L1_BUSY matches L1_LOAD.
2. Start a 4-byte burst, pulse COMMIT (COMMIT_LEN=2, new data AA,BB) on the 2nd byte cycle -> current burst still 11..44; COMMIT_PENDING high until the cycle after the last byte; next FRAME_START yields AA,BB.
3. With COMMIT_PENDING=1, pulse WR_EN addr 0 data 0xFF -> WR_REJECT pulse; next burst does not contain 0xFF. Separately, WR_ADDR=MAX_BYTES -> WR_REJECT.
4. During a burst, FRAME_START on the 1st and on the last byte cycle -> two OVERRUN pulses; the burst is unchanged and no second burst starts.
5. COMMIT_LEN=MAX_BYTES+5 -> burst of exactly MAX_BYTES bytes. COMMIT_LEN=0 -> FRAME_START gives no L1_LOAD and no OVERRUN.
6. Assert RST for 1 cycle mid-burst -> L1_LOAD=0 asynchronously; the subsequent FRAME_START gives no output; after a fresh COMMIT, normal bursts resume.
